// File: rtl/ipv4_packet_assembler_if.sv
// Packet output stream: one 32-bit word per valid/ready handshake, last marks the payload word.
interface ipv4_packet_assembler_if;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_word, output out_valid, output out_last, input out_ready);
    modport slave  (input out_word, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ipv4_packet_assembler.sv
// Builds a six-word IPv4 packet (20-byte header plus one payload word) and streams it out.
// Define IPV4_TX_CHKSUM_EN to compute the header checksum; otherwise the field is sent as zero.
module ipv4_packet_assembler #(
    parameter logic [7:0] TTL_DEFAULT = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  type_of_svc,
    input  logic [15:0] packet_identification,
    input  logic [2:0]  flags,
    input  logic [12:0] fragment_offset,
    input  logic [7:0]  time_to_live,
    input  logic [7:0]  protocol,
    input  logic [31:0] source_ip_address,
    input  logic [31:0] destination_ip_address,
    input  logic [31:0] data,
    ipv4_packet_assembler_if.master tx,
    output logic        busy,
    output logic [15:0] header_chksum
);
    localparam logic [1:0] IDLE   = 2'd0;
`ifdef IPV4_TX_CHKSUM_EN
    localparam logic [1:0] CHKSUM = 2'd1;
`endif
    localparam logic [1:0] SEND   = 2'd2;
`ifdef IPV4_TX_CHKSUM_EN
    localparam logic [1:0] FIRST  = CHKSUM;
`else
    localparam logic [1:0] FIRST  = SEND;
`endif

    logic [1:0]  state_q;
    logic [2:0]  idx_q;
    logic [7:0]  tos_q;
    logic [15:0] id_q;
    logic [2:0]  flags_q;
    logic [12:0] offset_q;
    logic [7:0]  ttl_q;
    logic [7:0]  proto_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] data_q;
    logic [31:0] hdr_word;
    logic        accept;

    // Word selected by idx_q with the checksum field left at zero; shared by summing and sending.
    always_comb begin
        hdr_word = 32'h0;
        case (idx_q)
            3'd0:    hdr_word = {4'd4, 4'd5, tos_q, 16'd24};
            3'd1:    hdr_word = {id_q, flags_q, offset_q};
            3'd2:    hdr_word = {ttl_q, proto_q, 16'h0000};
            3'd3:    hdr_word = src_q;
            3'd4:    hdr_word = dst_q;
            3'd5:    hdr_word = data_q;
            default: hdr_word = 32'h0;
        endcase
    end

    assign tx.out_valid = (state_q == SEND);
    assign tx.out_last  = (state_q == SEND) && (idx_q == 3'd5);
    assign tx.out_word  = (state_q != SEND) ? 32'h0 :
                          (idx_q == 3'd2)   ? (hdr_word | {16'h0000, header_chksum}) : hdr_word;
    assign busy         = (state_q != IDLE);
    assign accept       = tx.out_valid && tx.out_ready;

`ifdef IPV4_TX_CHKSUM_EN
    logic [19:0] acc_q;
    logic [19:0] acc_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] chk_q;

    assign acc_sum = acc_q + {4'h0, hdr_word[31:16]} + {4'h0, hdr_word[15:0]};
    // Two end-around folds are enough: the first leaves at most one carry bit.
    assign fold1   = {1'b0, acc_sum[15:0]} + {13'h0, acc_sum[19:16]};
    assign fold2   = fold1[15:0] + {15'h0, fold1[16]};
    assign header_chksum = chk_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= 20'h0;
            chk_q <= 16'h0;
        end else if (state_q == IDLE && start) begin
            acc_q <= 20'h0;
        end else if (state_q == CHKSUM) begin
            acc_q <= acc_sum;
            if (idx_q == 3'd4) chk_q <= ~fold2;
        end
    end
`else
    assign header_chksum = 16'h0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            tos_q    <= 8'h0;
            id_q     <= 16'h0;
            flags_q  <= 3'h0;
            offset_q <= 13'h0;
            ttl_q    <= 8'h0;
            proto_q  <= 8'h0;
            src_q    <= 32'h0;
            dst_q    <= 32'h0;
            data_q   <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tos_q    <= type_of_svc;
                        id_q     <= packet_identification;
                        flags_q  <= flags;
                        offset_q <= fragment_offset;
                        ttl_q    <= (time_to_live == 8'd0) ? TTL_DEFAULT : time_to_live;
                        proto_q  <= protocol;
                        src_q    <= source_ip_address;
                        dst_q    <= destination_ip_address;
                        data_q   <= data;
                        idx_q    <= 3'd0;
                        state_q  <= FIRST;
                    end
                end
`ifdef IPV4_TX_CHKSUM_EN
                CHKSUM: begin
                    if (idx_q == 3'd4) begin
                        idx_q   <= 3'd0;
                        state_q <= SEND;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
`endif
                SEND: begin
                    if (accept) begin
                        if (idx_q == 3'd5) begin
                            idx_q   <= 3'd0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipv4_packet_assembler.sv
// Self-checking bench for ipv4_packet_assembler: directed and random packets against a word-level model.
module tb_ipv4_packet_assembler;
`ifdef IPV4_TX_CHKSUM_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [7:0]  tos;
        logic [15:0] id;
        logic [2:0]  flg;
        logic [12:0] off;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] dat;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  type_of_svc;
    logic [15:0] packet_identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  time_to_live;
    logic [7:0]  protocol;
    logic [31:0] source_ip_address;
    logic [31:0] destination_ip_address;
    logic [31:0] data;
    logic        busy;
    logic [15:0] header_chksum;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_w [6];
    logic [15:0] exp_chk;

    ipv4_packet_assembler_if tx_if ();

    ipv4_packet_assembler dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .type_of_svc            (type_of_svc),
        .packet_identification  (packet_identification),
        .flags                  (flags),
        .fragment_offset        (fragment_offset),
        .time_to_live           (time_to_live),
        .protocol               (protocol),
        .source_ip_address      (source_ip_address),
        .destination_ip_address (destination_ip_address),
        .data                   (data),
        .tx                     (tx_if.master),
        .busy                   (busy),
        .header_chksum          (header_chksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the packet as a list of words, checksum by one's-complement arithmetic on ints.
    function automatic void build_model(input pkt_t p);
        int unsigned s;
        logic [7:0]  ttl;
        ttl      = (p.ttl == 8'd0) ? 8'd64 : p.ttl;
        exp_w[0] = {8'h45, p.tos, 16'd24};
        exp_w[1] = {p.id, p.flg, p.off};
        exp_w[2] = {ttl, p.proto, 16'h0000};
        exp_w[3] = p.src;
        exp_w[4] = p.dst;
        exp_w[5] = p.dat;
        s = 0;
        for (int i = 0; i < 5; i++) s += int'(exp_w[i][31:16]) + int'(exp_w[i][15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
`ifdef IPV4_TX_CHKSUM_EN
        exp_chk = ~s[15:0];
`else
        exp_chk = 16'h0000;
`endif
        exp_w[2][15:0] = exp_chk;
    endfunction

    task automatic drive_fields(input pkt_t p);
        type_of_svc            = p.tos;
        packet_identification  = p.id;
        flags                  = p.flg;
        fragment_offset        = p.off;
        time_to_live           = p.ttl;
        protocol               = p.proto;
        source_ip_address      = p.src;
        destination_ip_address = p.dst;
        data                   = p.dat;
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.tos   = 8'($urandom);
        p.id    = 16'($urandom);
        p.flg   = 3'($urandom);
        p.off   = 13'($urandom);
        p.ttl   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        p.proto = 8'($urandom);
        p.src   = $urandom;
        p.dst   = $urandom;
        p.dat   = $urandom;
        return p;
    endfunction

    // ready_mode: 0 always ready, 1 alternate 1-0-1, 2 random. abort_at >= 0 resets after that many words.
    task automatic run_packet(input pkt_t p, input int ready_mode, input bit hold_start,
                              input int abort_at);
        int k;
        int cyc;
        int guard;
        bit rdy;
        build_model(p);
        @(negedge clk);
        drive_fields(p);
        start = 1'b1;
        tx_if.out_ready = (ready_mode == 0);
        @(negedge clk);
        check("busy_after_start", busy, 1);
        if (!hold_start) start = 1'b0;
        drive_fields(rand_pkt());
        cyc = 1;
        while (!tx_if.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("first_valid_latency", cyc, LAT);
        k = 0;
        guard = 0;
        rdy = 1'b0;
        while (k < 6 && guard < 200) begin
            check("out_valid", tx_if.out_valid, 1);
            check($sformatf("word%0d", k + 1), tx_if.out_word, exp_w[k]);
            check($sformatf("last%0d", k + 1), tx_if.out_last, (k == 5));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = 1'($urandom);
            endcase
            tx_if.out_ready = rdy;
            if (rdy) k++;
            @(negedge clk);
            guard++;
            if (abort_at >= 0 && k == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_out_word", tx_if.out_word, 0);
                check("rst_out_valid", tx_if.out_valid, 0);
                check("rst_out_last", tx_if.out_last, 0);
                check("rst_busy", busy, 0);
                check("rst_chksum", header_chksum, 0);
                start = 1'b0;
                tx_if.out_ready = 1'b0;
                return;
            end
        end
        check("accept_budget", (guard < 200), 1);
        check("done_valid", tx_if.out_valid, 0);
        check("done_last", tx_if.out_last, 0);
        check("done_busy", busy, 0);
        check("header_chksum", header_chksum, exp_chk);
        start = 1'b0;
        tx_if.out_ready = 1'($urandom);
        @(negedge clk);
        check("stay_idle", busy, 0);
        check("chksum_held", header_chksum, exp_chk);
        tx_if.out_ready = 1'b0;
    endtask

    initial begin
        pkt_t p0;
        pkt_t pz;
        reset = 1'b0;
        start = 1'b0;
        tx_if.out_ready = 1'b0;
        p0 = '{tos: 8'h01, id: 16'h0000, flg: 3'b010, off: 13'h0, ttl: 8'h7B, proto: 8'h06,
               src: 32'hC000_0001, dst: 32'hC400_0001, dat: 32'hC400_0007};
        drive_fields(p0);
        repeat (3) @(negedge clk);
        check("reset_word", tx_if.out_word, 0);
        check("reset_valid", tx_if.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_chksum", header_chksum, 0);
        reset = 1'b1;
        @(negedge clk);

        run_packet(p0, 0, 1'b0, -1);
        run_packet(p0, 1, 1'b0, -1);
        pz = p0;
        pz.ttl = 8'd0;
        run_packet(pz, 0, 1'b0, -1);
        run_packet(p0, 2, 1'b1, -1);
        run_packet(p0, 0, 1'b0, 3);
        @(negedge clk);
        reset = 1'b1;
        run_packet(p0, 0, 1'b0, -1);
        for (int i = 0; i < 25; i++) begin
            run_packet(rand_pkt(), $urandom_range(0, 2), 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
